// File: rtl/data_mem_dump_reader_pkg.sv
// Shared definitions for the data-memory dump reader: FSM encoding,
// default widths and the layout of one skid-FIFO entry {addr, data, last}.
package mips_dump_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } dump_state_t;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
    logic                  last;
  } dump_entry_t;

  localparam int ENTRY_W = $bits(dump_entry_t);

  // Entry width for non-default address/data widths.
  function automatic int entry_w(input int aw, input int dw);
    return aw + dw + 1;
  endfunction

endpackage

// File: rtl/data_mem_dump_reader_if.sv
// Streaming output port of the dump reader (valid/ready with address and
// last-word marker). master = the reader, slave = the host/sink.
interface data_mem_dump_reader_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) ();

  logic [DATA_W-1:0] dout;
  logic [ADDR_W-1:0] dout_addr;
  logic              dout_valid;
  logic              dout_ready;
  logic              dout_last;

  modport master (
    output dout,
    output dout_addr,
    output dout_valid,
    output dout_last,
    input  dout_ready
  );

  modport slave (
    input  dout,
    input  dout_addr,
    input  dout_valid,
    input  dout_last,
    output dout_ready
  );

endinterface

// File: rtl/data_mem_dump_reader_skid_fifo.sv
// dump_skid_fifo: small synchronous FIFO used as the output skid buffer.
// A push while full is accepted only when a pop happens in the same cycle,
// leaving the occupancy unchanged.
module dump_skid_fifo #(
  parameter int WIDTH = 43,
  parameter int DEPTH = 2,
  parameter int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] store [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (level == '0);
  assign full    = (level == LVL_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = store[rd_ptr];

  // Pointer and occupancy bookkeeping; reset empties the FIFO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Entry storage, data only, never reset.
  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= din;
  end

endmodule

// File: rtl/data_mem_dump_reader.sv
// data_mem_dump_reader: walks data memory from base_addr for count words
// (clamped to 2**ADDR_W, addresses wrap) and streams {data, addr, last}
// over a valid/ready port through a skid FIFO. Reads are only issued when
// the FIFO can absorb every outstanding read, counting a pop in the same
// cycle, which sustains one word per cycle with a 2-entry FIFO.
// Optional feature macro: DUMP_CHECKSUM_EN adds a checksum output holding
// the wrapping sum of all transferred words of the last dump.
module data_mem_dump_reader
  import mips_dump_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int FIFO_D = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W:0]     count,
  output logic                mem_rd_en,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy,
  output logic                done,
`ifdef DUMP_CHECKSUM_EN
  output logic [DATA_W-1:0]   checksum,
`endif
  data_mem_dump_reader_if.master dout_if
);

  localparam int EW    = entry_w(ADDR_W, DATA_W);
  localparam int LVL_W = $clog2(FIFO_D + 1);
  localparam logic [ADDR_W:0] MAX_CNT = {1'b1, {ADDR_W{1'b0}}};

  dump_state_t       state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   remain_q;
  logic [ADDR_W:0]   cnt_clamped;
  logic              rd_en;
  logic              rd_last;
  logic              rd_ok;

  logic              pend_p1;
  logic [ADDR_W-1:0] pend_addr_p1;
  logic              pend_last_p1;

  logic [EW-1:0]     fifo_din;
  logic [EW-1:0]     fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic [LVL_W-1:0]  fifo_level;
  logic              fifo_vld;
  logic              pop;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic              head_last;
  logic [LVL_W:0]    used;
  logic [LVL_W:0]    cap;

  assign cnt_clamped = (count > MAX_CNT) ? MAX_CNT : count;
  assign rd_last     = (remain_q == {{ADDR_W{1'b0}}, 1'b1});

  assign used  = {1'b0, fifo_level} + {{LVL_W{1'b0}}, pend_p1};
  assign cap   = (LVL_W + 1)'(FIFO_D) + {{LVL_W{1'b0}}, pop};
  assign rd_ok = (used < cap);

  assign rd_en     = (state == ST_READ) && rd_ok;
  assign mem_rd_en = rd_en;
  assign mem_addr  = addr_q;

  assign fifo_vld  = !fifo_empty;
  assign pop       = fifo_vld && dout_if.dout_ready;
  assign head_addr = fifo_dout[EW-1 -: ADDR_W];
  assign head_data = fifo_dout[DATA_W:1];
  assign head_last = fifo_dout[0];

  assign dout_if.dout_valid = fifo_vld;
  assign dout_if.dout       = fifo_vld ? head_data : '0;
  assign dout_if.dout_addr  = fifo_vld ? head_addr : '0;
  assign dout_if.dout_last  = fifo_vld && head_last;

  // Next-state and status decode.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = (count == '0) ? ST_DONE : ST_READ;
      end
      ST_READ: begin
        busy = 1'b1;
        if (rd_en && rd_last) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (pop && head_last) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Control state: FSM, address/remaining counters, read-in-flight flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      pend_p1  <= 1'b0;
    end else begin
      state   <= state_nxt;
      pend_p1 <= rd_en;
      if (state == ST_IDLE && start) begin
        addr_q   <= base_addr;
        remain_q <= cnt_clamped;
      end else if (rd_en) begin
        addr_q   <= addr_q + 1'b1;
        remain_q <= remain_q - 1'b1;
      end
    end
  end

  // Stage p0 -> p1: remember address/last of the read whose data returns next cycle.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      pend_addr_p1 <= addr_q;
      pend_last_p1 <= rd_last;
    end
  end

  // Stage p1 -> FIFO: returned word pushed together with its address.
  assign fifo_din = {pend_addr_p1, mem_rdata, pend_last_p1};

  dump_skid_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_D),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (pend_p1),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

`ifdef DUMP_CHECKSUM_EN
  // Running sum of accepted words, cleared when a dump starts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      checksum <= '0;
    end else if (state == ST_IDLE && start) begin
      checksum <= '0;
    end else if (pop) begin
      checksum <= checksum + head_data;
    end
  end
`endif

endmodule
